// File: rtl/fp_div_iter_if.sv
// Floating-point format/rounding-mode definitions and the operand/result interface of the
// iterative divider; the package sits in front of the interface that depends on it.
package fp_pkg;
  typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;
  typedef enum logic [2:0] {RNE, RTZ, RDN, RUP, RMM} roundmode_e;

  function automatic int unsigned exp_bits(fp_format_e f);
    case (f)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned mant_bits(fp_format_e f);
    case (f)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int unsigned fp_width(fp_format_e f);
    return 1 + exp_bits(f) + mant_bits(f);
  endfunction
endpackage

interface fp_div_iter_if import fp_pkg::*; #(
  parameter fp_format_e FP_FORMAT = FP32
);
  localparam int unsigned FW = fp_width(FP_FORMAT);

  logic          start_i;
  logic          kill_i;
  logic [FW-1:0] a_i;
  logic [FW-1:0] b_i;
  roundmode_e    rnd_i;
  logic          ready_o;
  logic          done_o;
  logic          dz_o;
  // {u_result, rs[1:0], round_en, invalid, exp_cout[1:0]}
  logic [FW+5:0] urnd_result_o;

  modport master (output start_i, kill_i, a_i, b_i, rnd_i,
                  input  ready_o, done_o, dz_o, urnd_result_o);
  modport slave  (input  start_i, kill_i, a_i, b_i, rnd_i,
                  output ready_o, done_o, dz_o, urnd_result_o);
endinterface

// File: rtl/fp_div_iter.sv
// Multi-cycle restoring IEEE-754 divider: produces an unrounded quotient with round/sticky
// bits and a widened signed exponent for the shared rounder.
module fp_div_iter import fp_pkg::*; #(
  parameter fp_format_e  FP_FORMAT  = FP32,
  parameter int unsigned RADIX_BITS = 1
) (
  input logic          clk_i,
  input logic          reset_i,
  fp_div_iter_if.slave bus
);
  localparam int unsigned EW    = exp_bits(FP_FORMAT);
  localparam int unsigned MW    = mant_bits(FP_FORMAT);
  localparam int unsigned FW    = 1 + EW + MW;
  localparam int unsigned RW    = MW + 2;
  localparam int unsigned XW    = EW + 2;
  localparam int unsigned ITERS = (RW + RADIX_BITS - 1) / RADIX_BITS;
  localparam int unsigned QW    = ITERS * RADIX_BITS;
  localparam int unsigned CW    = $clog2(ITERS);
  localparam int unsigned LW    = $clog2(MW + 2);
  localparam logic [XW-1:0] BIAS = XW'((1 << (EW - 1)) - 1);
  localparam logic [FW-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_NORM, S_SPEC, S_DONE} state_e;
  typedef struct packed {logic nan; logic snan; logic inf; logic zero;} fp_class_t;
  typedef struct packed {logic [XW-1:0] exp; logic [MW:0] sig;} op_t;
  typedef struct packed {
    logic [FW-1:0] u_result;
    logic [1:0]    rs;
    logic          round_en;
    logic          invalid;
    logic [1:0]    exp_cout;
  } uround_res_t;

  function automatic fp_class_t classify(input logic [FW-1:0] x);
    fp_class_t c;
    logic [EW-1:0] e;
    e      = x[FW-2 -: EW];
    c.nan  = (&e) && (|x[MW-1:0]);
    c.snan = c.nan && !x[MW-1];
    c.inf  = (&e) && !(|x[MW-1:0]);
    c.zero = !(|e) && !(|x[MW-1:0]);
    return c;
  endfunction

  function automatic logic [LW-1:0] lzc(input logic [MW:0] s);
    logic [LW-1:0] cnt;
    logic          found;
    cnt   = '0;
    found = 1'b0;
    for (int i = MW; i >= 0; i--) begin
      if (s[i]) found = 1'b1;
      else if (!found) cnt = cnt + LW'(1);
    end
    return cnt;
  endfunction

  // Subnormals carry hidden bit 0 and effective exponent 1; the shift restores a leading one.
  function automatic op_t norm_op(input logic [FW-1:0] x);
    op_t           o;
    logic [EW-1:0] e;
    logic [MW:0]   s;
    logic [LW-1:0] lz;
    e     = x[FW-2 -: EW];
    s     = {|e, x[MW-1:0]};
    lz    = lzc(s);
    o.sig = s << lz;
    o.exp = XW'((|e) ? e : EW'(1)) - XW'(lz);
    return o;
  endfunction

  state_e        state_q, state_d;
  logic [FW-1:0] a_q, b_q;
  roundmode_e    rnd_q;
  logic [RW-1:0] rem_q;
  logic [MW:0]   div_q;
  logic [QW-1:0] quot_q;
  logic [XW-1:0] exp_q;
  logic [CW-1:0] cnt_q;
  uround_res_t   res_q, res_d;
  logic          dz_q, dz_d;

  fp_class_t     in_a, in_b, ca, cb;
  logic          in_special, accept, sign;
  op_t           op_a, op_b;
  logic [XW-1:0] pre_exp;
  logic [RW-1:0] pre_rem, iter_rem, q_main;
  logic [QW-1:0] iter_quot;
  logic          q_tail;

  assign in_a       = classify(bus.a_i);
  assign in_b       = classify(bus.b_i);
  assign in_special = in_a.nan | in_a.inf | in_a.zero | in_b.nan | in_b.inf | in_b.zero;
  assign accept     = (state_q == S_IDLE) && bus.start_i && !bus.kill_i;

  // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (accept) state_d = in_special ? S_SPEC : S_PRE;
      S_PRE:          state_d = S_ITER;
      S_ITER:         if (cnt_q == '0) state_d = S_NORM;
      S_NORM, S_SPEC: state_d = S_DONE;
      S_DONE:         state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
    if (bus.kill_i && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Pre-scale the dividend so the quotient lands in [1,2).
  always_comb begin
    op_a    = norm_op(a_q);
    op_b    = norm_op(b_q);
    pre_exp = op_a.exp - op_b.exp + BIAS;
    pre_rem = {1'b0, op_a.sig};
    if (op_a.sig < op_b.sig) begin
      pre_rem = {op_a.sig, 1'b0};
      pre_exp = pre_exp - XW'(1);
    end
  end

  // NOTE: blocking assignments here chain RADIX_BITS restoring steps within one cycle.
  always_comb begin
    iter_rem  = rem_q;
    iter_quot = quot_q;
    for (int k = 0; k < RADIX_BITS; k++) begin
      if (iter_rem >= {1'b0, div_q}) begin
        iter_rem  = iter_rem - {1'b0, div_q};
        iter_quot = {iter_quot[QW-2:0], 1'b1};
      end else begin
        iter_quot = {iter_quot[QW-2:0], 1'b0};
      end
      iter_rem = iter_rem << 1;
    end
  end

  always_comb begin
    ca     = classify(a_q);
    cb     = classify(b_q);
    sign   = a_q[FW-1] ^ b_q[FW-1];
    q_main = quot_q[QW-1 -: RW];
    q_tail = |(quot_q << RW);
    res_d  = '0;
    dz_d   = 1'b0;
    if (state_q == S_NORM) begin
      res_d.u_result = {sign, exp_q[EW-1:0], q_main[RW-2:1]};
      res_d.rs       = {q_main[0], (|rem_q) | q_tail};
      res_d.round_en = 1'b1;
      res_d.exp_cout = exp_q[XW-1:EW];
    end else if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf)) begin
      res_d.u_result = QNAN;
      res_d.invalid  = ca.snan | cb.snan | (ca.zero & cb.zero) | (ca.inf & cb.inf);
    end else if (cb.zero) begin
      res_d.u_result = {sign, {EW{1'b1}}, {MW{1'b0}}};
      dz_d           = !ca.inf;
    end else if (ca.inf) begin
      res_d.u_result = {sign, {EW{1'b1}}, {MW{1'b0}}};
    end else begin
      res_d.u_result = {sign, {(FW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_q    <= '0;
      b_q    <= '0;
      rnd_q  <= RNE;
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      exp_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.a_i;
        b_q   <= bus.b_i;
        rnd_q <= bus.rnd_i;
      end
      case (state_q)
        S_PRE: begin
          rem_q  <= pre_rem;
          div_q  <= op_b.sig;
          exp_q  <= pre_exp;
          quot_q <= '0;
          cnt_q  <= CW'(ITERS - 1);
        end
        S_ITER: begin
          rem_q  <= iter_rem;
          quot_q <= iter_quot;
          cnt_q  <= cnt_q - CW'(1);
        end
        default: ;
      endcase
      if (state_d == S_DONE) begin
        res_q <= res_d;
        dz_q  <= dz_d;
      end
    end
  end

  // Division zeros always take the XOR sign, so the captured mode has no effect here.
  logic unused_rnd;
  assign unused_rnd = ^rnd_q;

  assign bus.ready_o       = (state_q == S_IDLE);
  assign bus.done_o        = (state_q == S_DONE);
  assign bus.dz_o          = dz_q;
  assign bus.urnd_result_o = res_q;
endmodule

// File: tb/tb_fp_div_iter.sv
// Randomised scoreboard bench for fp_div_iter (FP32, one quotient bit per cycle): an
// integer-arithmetic reference model fills a queue that a done_o monitor drains.
module tb_fp_div_iter;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_div_iter_if #(.FP_FORMAT(FP32)) bus();
  fp_div_iter #(.FP_FORMAT(FP32), .RADIX_BITS(1)) u_dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  typedef struct {
    logic [37:0] urnd;
    logic        dz;
    int          lat;
    int          start_cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [37:0] last_urnd   = '0;
  logic        last_dz     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] u, input logic [1:0] rs, input logic ren,
                              input logic inv, input logic [1:0] cout, input logic dz, input int lat);
    exp_t e;
    e.urnd = {u, rs, ren, inv, cout};
    e.dz   = dz;
    e.lat  = lat;
    e.start_cyc = 0;
    e.a = '0;
    e.b = '0;
    return e;
  endfunction

  // Value-level reference: a/b = (na/nb) * 2^(xa-xb); scale na until the integer quotient
  // has 25 bits (hidden, 23 fraction bits, round bit), sticky = nonzero remainder.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, xa, xb, k, e;
    longint fa, fb, na, nb, q, rem;
    logic   s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv;
    logic [9:0] e10;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    s  = a[31] ^ b[31];
    a_nan  = (ea == 255) && (fa != 0);  b_nan  = (eb == 255) && (fb != 0);
    a_inf  = (ea == 255) && (fa == 0);  b_inf  = (eb == 255) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);    b_zero = (eb == 0) && (fb == 0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      inv = (a_nan && !a[22]) || (b_nan && !b[22]) || (a_zero && b_zero) || (a_inf && b_inf);
      return mk(32'h7FC00000, 2'b00, 1'b0, inv, 2'b00, 1'b0, 2);
    end
    if (b_zero) return mk({s, 31'h7F800000}, 2'b00, 1'b0, 1'b0, 2'b00, !a_inf, 2);
    if (a_inf)  return mk({s, 31'h7F800000}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2);
    if (a_zero || b_inf) return mk({s, 31'h0}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2);
    na = (ea == 0) ? fa : (fa | (64'sd1 << 23));
    nb = (eb == 0) ? fb : (fb | (64'sd1 << 23));
    xa = ((ea == 0) ? 1 : ea) - 150;
    xb = ((eb == 0) ? 1 : eb) - 150;
    k = 0;
    while (((na << k) / nb) < (64'sd1 << 24) && k < 60) k++;
    q   = (na << k) / nb;
    rem = (na << k) % nb;
    e   = xa - xb - k + 24 + 127;
    e10 = 10'(e);
    return mk({s, e10[7:0], q[23:1]}, {q[0], rem != 0}, 1'b1, 1'b0, e10[9:8], 1'b0, 28);
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 7))
      0: x[30:23] = 8'h00;
      1: begin
        x[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) x[22:0] = '0;
      end
      2: x[30:0] = '0;
      3: x[30:23] = 8'($urandom_range(120, 134));
      default: ;
    endcase
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(bus.done_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("result %h/%h", e.a, e.b), {25'd0, bus.dz_o, bus.urnd_result_o},
              {25'd0, e.dz, e.urnd});
        check($sformatf("latency %h/%h", e.a, e.b), 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) check("ready_timeout", 64'(bus.ready_o), 64'd1);
  endtask

  task automatic start_raw(input logic [31:0] a, input logic [31:0] b);
    bus.a_i     = a;
    bus.b_i     = b;
    bus.rnd_i   = roundmode_e'($urandom_range(0, 4));
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic issue_e(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    wait_ready();
    e.start_cyc = cyc;
    e.a = a;
    e.b = b;
    sb_q.push_back(e);
    last_urnd = e.urnd;
    last_dz   = e.dz;
    start_raw(a, b);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    issue_e(a, b, model(a, b));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_done"}, 64'(bus.done_o), 64'd0);
    check({tag, "_dz"}, 64'(bus.dz_o), 64'd0);
    check({tag, "_urnd"}, 64'(bus.urnd_result_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.rnd_i   = RNE;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    issue_e(32'h40C00000, 32'h40000000, mk(32'h40400000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 28));
    check("ready_drops", 64'(bus.ready_o), 64'd0);
    issue_e(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 28));
    issue_e(32'h00000000, 32'h00000000, mk(32'h7FC00000, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2));
    issue_e(32'hBF800000, 32'h00000000, mk(32'hFF800000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 2));
    issue_e(32'h00000001, 32'h3F800000, mk(32'h75000000, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 28));
    drain();

    for (int i = 0; i < 60; i++) issue(rand_op(), rand_op());
    drain();

    // Stray start while busy must not disturb the running operation.
    wait_ready();
    base = cyc;
    issue(32'h40E00000, 32'h40000000);
    while (cyc < base + 5) @(negedge clk);
    start_raw(32'h3F800000, 32'h3F800000);
    drain();

    // kill together with start in IDLE leaves the block idle.
    repeat (2) @(negedge clk);
    bus.kill_i = 1'b1;
    start_raw(32'h40C00000, 32'h40000000);
    bus.kill_i = 1'b0;
    check("kill_start_idle", 64'(bus.ready_o), 64'd1);

    // Abort mid-operation: idle one cycle later, previous results untouched, no done.
    base = cyc;
    start_raw(32'h3F800000, 32'h40400000);
    while (cyc < base + 10) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    check("kill_ready", 64'(bus.ready_o), 64'd1);
    check("kill_urnd_held", 64'(bus.urnd_result_o), 64'(last_urnd));
    check("kill_dz_held", 64'(bus.dz_o), 64'(last_dz));
    repeat (30) @(negedge clk);

    // Reset mid-operation returns every output to its reset value.
    base = cyc;
    start_raw(32'h40C00000, 32'h40400000);
    while (cyc < base + 12) @(negedge clk);
    rst = 1'b1;
    #2;
    check_idle_zero("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    issue(32'hC1200000, 32'h40800000);
    issue(32'h7F800000, 32'h3F800000);
    drain();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
